// File: rtl/tff_toggle_sched_pkg.sv
// tff_sched_pkg: shared definitions for the toggle-bank scheduler.
//   ptr_width  - width of a round-robin pointer / requester index for n requesters
//   idx_fits   - configuration check: bit-index field can address every bank bit
//   onehot_bit - one bit of the one-hot encode of an index (used per bank bit)
package tff_sched_pkg;

  localparam int MAX_WIDTH = 256;
  localparam int MIN_NREQ  = 2;
  localparam int MAX_NREQ  = 8;

  function automatic int ptr_width(input int nreq);
    return (nreq < 2) ? 1 : $clog2(nreq);
  endfunction

  function automatic bit idx_fits(input int idxw, input int width);
    return (width >= 1) && (width <= MAX_WIDTH) && (idxw >= 1) && (idxw < 31) &&
           ((1 << idxw) >= width);
  endfunction

  function automatic logic onehot_bit(input int unsigned idx, input int unsigned pos);
    return (idx == pos);
  endfunction

endpackage

// File: rtl/tff_toggle_sched_if.sv
// tff_toggle_sched_if: requester/consumer bundle of the toggle-bank scheduler.
//   req/sel/clear          - driven by the requesting control logic (master)
//   gnt/t_vec/state/count  - scheduler results (slave drives them)
//   err/busy               - out-of-range grant pulse and activity flag
interface tff_toggle_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = 3,
  parameter int CNTW  = 16
);
  logic [NREQ-1:0]      req;
  logic [NREQ*IDXW-1:0] sel;
  logic                 clear;
  logic [NREQ-1:0]      gnt;
  logic [WIDTH-1:0]     t_vec;
  logic [WIDTH-1:0]     state;
  logic [CNTW-1:0]      count;
  logic                 err;
  logic                 busy;

  modport master (
    output req, sel, clear,
    input  gnt, t_vec, state, count, err, busy
  );

  modport slave (
    input  req, sel, clear,
    output gnt, t_vec, state, count, err, busy
  );
endinterface

// File: rtl/tff_toggle_sched_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   elig    - eligibility mask, one bit per requester
//   ptr     - index with highest priority this cycle
//   win_oh  - one-hot winner (zero when nobody is eligible)
//   win_idx - binary index of the winner
//   any     - at least one requester is eligible
module rr_pick
  import tff_sched_pkg::*;
#(
  parameter int  NREQ = 4,
  localparam int PTRW = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] elig,
  input  logic [PTRW-1:0] ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [PTRW-1:0] win_idx,
  output logic            any
);

  // Scan offsets from farthest to nearest so the last hit, which is the
  // one closest to ptr, is what remains.
  always_comb begin
    int cand;
    cand    = 0;
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = (int'(ptr) + off) % NREQ;
      if (elig[cand]) begin
        win_oh       = '0;
        win_oh[cand] = 1'b1;
        win_idx      = PTRW'(cand);
        any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tff_toggle_sched.sv
// tff_toggle_sched: round-robin scheduler sharing one bank of WIDTH toggle
// flip-flops between NREQ requesters.
//   clock - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - slave side of tff_toggle_sched_if (req/sel/clear in;
//           gnt/t_vec/state/count/err/busy out)
// Edge k arbitrates and registers gnt/t_vec/err; edge k+1 applies t_vec to
// the bank and counter, so arbitration and apply overlap every cycle.
module tff_toggle_sched
  import tff_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = 3,
  parameter int CNTW  = 16
) (
  input  logic               clock,
  input  logic               reset,
  tff_toggle_sched_if.slave  bus
);

  localparam int PTRW = ptr_width(NREQ);

  if (!idx_fits(IDXW, WIDTH) || NREQ < MIN_NREQ || NREQ > MAX_NREQ) begin : g_bad_cfg
    $error("tff_toggle_sched: unsupported NREQ/WIDTH/IDXW combination");
  end

  logic [NREQ-1:0]  gnt_reg;
  logic [WIDTH-1:0] t_vec_reg;
  logic [WIDTH-1:0] state_reg;
  logic [CNTW-1:0]  count_reg;
  logic             err_reg;
  logic [PTRW-1:0]  ptr_reg;

  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  win_oh;
  logic [PTRW-1:0]  win_idx;
  logic             win_any;
  logic [IDXW-1:0]  sel_arr [NREQ];
  logic [IDXW-1:0]  sel_w;
  logic             sel_in_range;
  logic [WIDTH-1:0] sel_oh;
  logic [PTRW-1:0]  ptr_next;

  // A requester whose grant is currently showing is taken as acknowledged.
  assign elig = bus.req & ~gnt_reg;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .elig    (elig),
    .ptr     (ptr_reg),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (win_any)
  );

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_sel
    assign sel_arr[gi] = bus.sel[gi*IDXW +: IDXW];
  end

  assign sel_w        = sel_arr[win_idx];
  assign sel_in_range = (32'(sel_w) < 32'(WIDTH));

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_oh
    assign sel_oh[gi] = onehot_bit(32'(sel_w), gi);
  end

  assign ptr_next = (win_idx == PTRW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gnt_reg   <= '0;
      t_vec_reg <= '0;
      state_reg <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
      ptr_reg   <= '0;
    end else if (bus.clear) begin
      // Drops the pending toggle as well; ptr keeps its position.
      gnt_reg   <= '0;
      t_vec_reg <= '0;
      state_reg <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_reg ^ t_vec_reg;
      if (|t_vec_reg) begin
        count_reg <= count_reg + CNTW'(1);
      end
      if (win_any) begin
        gnt_reg <= win_oh;
        ptr_reg <= ptr_next;
        // Out-of-range index still consumes the grant, just toggles nothing.
        if (sel_in_range) begin
          t_vec_reg <= sel_oh;
          err_reg   <= 1'b0;
        end else begin
          t_vec_reg <= '0;
          err_reg   <= 1'b1;
        end
      end else begin
        gnt_reg   <= '0;
        t_vec_reg <= '0;
        err_reg   <= 1'b0;
      end
    end
  end

  assign bus.gnt   = gnt_reg;
  assign bus.t_vec = t_vec_reg;
  assign bus.state = state_reg;
  assign bus.count = count_reg;
  assign bus.err   = err_reg;
  assign bus.busy  = (|bus.req) | (|t_vec_reg);

endmodule

// File: doc/tff_toggle_sched.md
Name: tff_toggle_sched

Overview:
- Round-robin scheduler that shares one bank of WIDTH toggle flip-flops between NREQ requesters.
- Each requester asks to toggle one bit of the bank. The block grants one requester per cycle and drives a one-hot toggle-enable vector into the internal bank.
- It exposes the bank state, a toggle counter and an error pulse.
- It sits between control logic that issues toggle requests and downstream logic that consumes the toggle-register state.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, number of toggle flip-flops in the bank (1..256).
- IDXW, 3, width of each bit-index field; must satisfy 2**IDXW >= WIDTH.
- CNTW, 16, width of the toggle counter.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset: asserting low immediately clears all state; deassertion is synchronous to clock.
- req  in  NREQ  per-requester toggle request, level.
- sel  in  NREQ*IDXW  per-requester bit index; requester i uses bits [i*IDXW +: IDXW].
- clear  in  1  synchronous clear of bank and counter.
- gnt  out  NREQ  one-hot grant pulse, registered.
- t_vec  out  WIDTH  one-hot toggle enable currently applied to the bank, registered.
- state  out  WIDTH  toggle-bank contents.
- count  out  CNTW  number of toggles applied, wraps.
- err  out  1  pulse: the granted index was >= WIDTH.
- busy  out  1  high when any req is pending or t_vec != 0.

Behaviour:
- Reset (reset low, asynchronous): gnt=0, t_vec=0, state=0, count=0, err=0, round-robin pointer ptr=0.
- Eligibility at edge k: requester i is eligible iff req[i]=1 and gnt[i]=0.
  - A requester sampled with its own gnt high is treated as acknowledged and is ignored for that edge.
  - The fastest rate for one requester is therefore one grant per two cycles.
- Arbitration at edge k, if clear=0 and any requester is eligible:
  - Winner w is the first eligible index scanning ptr, ptr+1, ... modulo NREQ.
  - gnt <= onehot(w); ptr <= (w+1) mod NREQ.
  - If sel_w < WIDTH: t_vec <= onehot(sel_w) and err <= 0.
  - If sel_w >= WIDTH: t_vec <= 0 and err <= 1. The grant is still issued and ptr still advances.
- No eligible requester: gnt <= 0, t_vec <= 0, err <= 0, ptr holds.
- Apply stage at edge k+1: state <= state ^ t_vec; count <= count + 1 if t_vec != 0. Total latency from request sampled to state change is 2 edges.
- Pipelining: arbitration and apply overlap, so a new grant can be issued every cycle to different requesters. Toggling the same bit on consecutive cycles is legal; each toggle applies in order.
- clear=1 at edge k, priority over everything:
  - state <= 0, count <= 0, gnt <= 0, t_vec <= 0, err <= 0, ptr holds.
  - The t_vec pending from edge k-1 is discarded: it is not applied and not counted.
  - Requests present at edge k are not granted; requesters keep req high and are served after clear drops.
- count wraps from 2**CNTW-1 to 0 with no flag.
- busy = (|req) | (|t_vec), combinational.
- Reset asserted mid-operation: all registers clear immediately; any in-flight grant or toggle is lost. After reset deassertion, arbitration resumes with ptr=0.
- Requester protocol: hold req and sel stable until gnt[i] is seen high; sel is sampled only at the granting edge.

Decomposition:
- Shared package tff_sched_pkg: IDXW/WIDTH relation check, localparam for pointer width $clog2(NREQ), and a function for the one-hot-of-index encode.
- One sub-module, rr_pick: combinational round-robin picker taking an eligibility mask and ptr, returning a one-hot winner and its index.
- The toggle bank, counter and pipeline registers stay in the top module.

Test Plan:
- Single request: reset, then req=4'b0001 with sel0=3 held until gnt → gnt=0001 at edge 1, t_vec=0x08, state=0x08 at edge 2, count=1.
- All four requesters with sel=0,1,2,3 and req=1111 held, each dropping req after its own gnt → grants in order 0,1,2,3 on consecutive cycles; final state=0x0F, count=4.
- Fairness: req0 and req1 held continuously with sel0=sel1=5 → grants alternate 0,1,0,1; bit 5 toggles every cycle; after 6 grants state=0x00, count=6.
- Out-of-range index: WIDTH=6, IDXW=3, sel2=7, req=0100 → gnt=0100, err pulses 1 cycle, t_vec=0, state unchanged, count unchanged.
- Clear with pending toggle: grant toggling bit 1 at edge k, clear=1 at edge k+1 → state=0 and count=0 at edge k+1; bit 1 is never set.
- Mid-operation reset and counter wrap:
  - With CNTW=2, apply 5 toggles → count sequence 1,2,3,0,1.
  - Then pulse reset low between edges → state, count, gnt and t_vec go 0 immediately without a clock edge.
